i2s_tdm_tx: RTL and testbench
=============================

Name: i2s_tdm_tx

Overview:
Parametrised successor to the fixed 2-channel, 8-bit I2S transmitter. It takes a full frame of NUM_CH samples over a valid/ready handshake and buffers one frame ahead. SCK is derived from clk through a programmable divider, and the block supports Philips-I2S and left-justified framing, stereo or TDM. Underflow is flagged as a sticky status bit. It sits between the sample sources (KS string, PRBS noise) and the uio pins; config and status go through the SPI register map.

Parameters:
AUDIO_DW, 8, sample width in bits; samples are sent MSB first.
SLOT_W, 8, bits per channel slot; must be >= AUDIO_DW; unused LSB positions are padded with 0.
NUM_CH, 2, channels per frame; must be >= 2; 2 = stereo WS, >2 = TDM frame sync.
DIV_W, 4, width of the SCK divider setting.

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
en_i  in  1  run enable
div_i  in  DIV_W  SCK half-period minus 1, in clk cycles
mode_i  in  1  0 = Philips I2S (data 1 bit after WS), 1 = left-justified
frame_data_i  in  NUM_CH*AUDIO_DW  channel k in bits [k*AUDIO_DW +: AUDIO_DW]
frame_valid_i  in  1  frame_data_i is valid
frame_ready_o  out  1  holding buffer empty
sck_o  out  1  serial bit clock
ws_o  out  1  word select / frame sync
sd_o  out  1  serial data
frame_start_o  out  1  one-clk pulse when a frame's bit 0 begins
underflow_o  out  1  sticky: a frame started with the buffer empty
underflow_clr_i  in  1  clears underflow_o

Behaviour:
- Reset values: sck_o=0, ws_o=0, sd_o=0, frame_start_o=0, underflow_o=0, frame_ready_o=1; buffer empty; serial shift register all 0; FSM in IDLE.
- Derived values: FRAME_BITS = NUM_CH*SLOT_W. Bit index b runs 0..FRAME_BITS-1. SCK period = 2*(div_i+1) clk cycles.
- FSM IDLE -> RUN on the first clk with en_i=1.
- That cycle is a "frame load":
  - b=0; frame_start_o pulses; sck_o stays 0.
  - div_i is latched. It is re-latched only at each frame load.
- RUN behaviour:
  - A divider counter toggles sck_o each (div_i+1) clk cycles.
  - On each sck_o 1->0 toggle, b increments and sd_o/ws_o update. Outputs are stable across the rising edge.
  - When b wraps FRAME_BITS-1 -> 0, a new frame load occurs.
- Frame load:
  - If the buffer is full, it moves to the shift frame and the buffer empties.
  - If the buffer is empty, the shift frame becomes all zeros and underflow_o is set to 1.
- Handshake:
  - frame_ready_o = !buffer_full (registered).
  - Transfer occurs on clk when frame_valid_i && frame_ready_o; the buffer fills the next cycle.
  - A transfer is accepted in IDLE, so the first frame can be preloaded.
  - No same-cycle drain+fill: after a load empties the buffer, ready rises the next cycle.
- Raw word select, ws_raw(b):
  - NUM_CH=2: ws_raw(b) = (b >= SLOT_W).
  - NUM_CH>2: ws_raw(b) = (b == 0).
  - ws_o = ws_raw(b) in both modes.
- Serial data:
  - Data index d = b in mode 1; d = (b-1) mod FRAME_BITS in mode 0.
  - slot = d / SLOT_W; pos = d mod SLOT_W.
  - sd_o = sample[slot][AUDIO_DW-1-pos] when pos < AUDIO_DW, else 0.
  - In mode 0, b=0 carries the previous frame's d=FRAME_BITS-1 bit. After reset or a restart this bit is 0.
- en_i=0 while in RUN:
  - Next clk: FSM goes to IDLE; sck_o, ws_o, sd_o go to 0; counters are cleared.
  - Buffer content and underflow_o are retained.
  - Re-enable restarts at b=0 with a frame load.
- Changes to mode_i are honoured only at a frame load.
- underflow_o:
  - Cleared when underflow_clr_i=1.
  - If set and clear occur in the same cycle, set wins.
- rst_n low mid-frame: all state returns to reset values on the next clk, regardless of en_i.

Decomposition:
- Package i2s_pkg:
  - Constants I2S_MODE_PHILIPS=0 and I2S_MODE_LJ=1.
  - Function frame_bits(num_ch, slot_w).
  - Function ws_raw(b, num_ch, slot_w).
- One natural sub-module, i2s_sck_gen:
  - Contains the divider counter and sck toggle.
  - Outputs sck_fall_o and sck_rise_o strobes.
  - Takes a restart input.
- Frame FSM, buffer and shift logic stay in i2s_tdm_tx.

Test Plan:
- Left-justified stereo. Setup: NUM_CH=2, SLOT_W=8, div_i=0, mode_i=1; preload frame_data_i=16'hA53C; set en_i=1.
  - sd_o over b0..15 = 0011_1100_1010_0101.
  - ws_o = 0 for b0..7 and 1 for b8..15.
  - sck_o period is 2 clk; frame_start_o pulses every 32 clk.
- Philips mode. Same setup with mode_i=0 and two frames 16'hA53C.
  - Frame 1: b0=0, then b1..15 = 0011_1100_1010_010.
  - Frame 2: b0=1, then the b1..15 pattern repeats.
  - ws_o is unchanged from the left-justified case.
- Underflow. Preload only one frame.
  - Second frame: sd_o all 0; underflow_o=1 from the cycle after that frame load.
  - Pulsing underflow_clr_i returns underflow_o to 0.
  - If a third frame also underflows, underflow_o is set again.
- Backpressure. Hold frame_valid_i=1 with 3 distinct frames.
  - frame_ready_o is low except for 1 cycle after each frame load.
  - Frames are transmitted in order, with no loss or duplication.
- TDM. NUM_CH=4, SLOT_W=16, AUDIO_DW=8, mode_i=1, channel 2 = 8'h81.
  - ws_o=1 only at b=0.
  - sd_o = 1000_0001 at b32..39; zeros at b40..47.
  - Frame length = 64 bits; at div_i=3 this is 512 clk.
- Abort. Drop en_i at b=5, then restore en_i 3 cycles later.
  - sck_o, ws_o and sd_o are 0 the next clk.
  - On restore, frame_start_o pulses and transmission restarts at b=0 with the buffered frame.
  - Repeat the test with rst_n low mid-frame: all outputs return to reset values.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared constants and framing helpers for the I2S / TDM transmitter.
package i2s_pkg;

  localparam logic I2S_MODE_PHILIPS = 1'b0;
  localparam logic I2S_MODE_LJ      = 1'b1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } i2s_state_e;

  function automatic int frame_bits(input int num_ch, input int slot_w);
    return num_ch * slot_w;
  endfunction

  // Stereo: WS marks the right half of the frame; TDM: a one-bit frame sync.
  function automatic logic ws_raw(input int b, input int num_ch, input int slot_w);
    if (num_ch == 2) begin
      return (b >= slot_w);
    end
    return (b == 0);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// Programmable SCK divider: emits one-clk strobes on the cycles where SCK
// rises or falls. restart_i holds the divider at phase 0 with SCK low.
module i2s_sck_gen #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             sck_rise_o,
  output logic             sck_fall_o
);

  logic [DIV_W-1:0] cnt_q;
  logic             phase_q;
  logic             tick;

  assign tick       = !restart_i && (cnt_q == div_i);
  assign sck_rise_o = tick && !phase_q;
  assign sck_fall_o = tick && phase_q;

  always_ff @(posedge clk) begin
    if (!rst_n || restart_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (tick) begin
      cnt_q   <= '0;
      phase_q <= !phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_tdm_tx.sv
// Frame-buffered I2S / left-justified / TDM serial transmitter with one
// frame of look-ahead buffering and a sticky underflow flag.
module i2s_tdm_tx
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW = 8,
  parameter int SLOT_W   = 8,
  parameter int NUM_CH   = 2,
  parameter int DIV_W    = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  input  logic [DIV_W-1:0]           div_i,
  input  logic                       mode_i,
  input  logic [NUM_CH*AUDIO_DW-1:0] frame_data_i,
  input  logic                       frame_valid_i,
  output logic                       frame_ready_o,
  output logic                       sck_o,
  output logic                       ws_o,
  output logic                       sd_o,
  output logic                       frame_start_o,
  output logic                       underflow_o,
  input  logic                       underflow_clr_i
);

  localparam int FB = frame_bits(NUM_CH, SLOT_W);
  localparam int BW = (FB > 1) ? $clog2(FB) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(FB - 1);

  i2s_state_e                 state_q;
  logic [BW-1:0]              b_q;
  logic [DIV_W-1:0]           div_q;
  logic                       mode_q;
  logic [FB-1:0]              shift_q;
  logic [FB-1:0]              frame_pad;
  logic [NUM_CH*AUDIO_DW-1:0] buf_q;
  logic                       buf_full_q, buf_full_d;
  logic                       ready_q;
  logic                       underflow_q, underflow_d;
  logic                       sck_q, ws_q, sd_q, fs_q;
  logic                       sck_rise, sck_fall;
  logic                       restart, load, xfer;

  // Buffered frame laid out MSB-first in transmit order, slot 0 leading.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
    assign frame_pad[FB-1-gi*SLOT_W -: SLOT_W] =
      SLOT_W'(buf_q[gi*AUDIO_DW +: AUDIO_DW]) << (SLOT_W - AUDIO_DW);
  end

  assign restart = (state_q == ST_IDLE) || !en_i;
  assign xfer    = frame_valid_i && ready_q;
  assign load    = en_i && ((state_q == ST_IDLE) || (sck_fall && (b_q == B_LAST)));

  i2s_sck_gen #(
    .DIV_W(DIV_W)
  ) u_sck_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart),
    .div_i     (div_q),
    .sck_rise_o(sck_rise),
    .sck_fall_o(sck_fall)
  );

  always_comb begin
    buf_full_d = buf_full_q;
    if (load) buf_full_d = 1'b0;
    if (xfer) buf_full_d = 1'b1;
    underflow_d = underflow_q;
    if (underflow_clr_i) underflow_d = 1'b0;
    if (load && !buf_full_q) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      b_q         <= '0;
      div_q       <= '0;
      mode_q      <= I2S_MODE_PHILIPS;
      shift_q     <= '0;
      buf_q       <= '0;
      buf_full_q  <= 1'b0;
      ready_q     <= 1'b1;
      underflow_q <= 1'b0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      buf_full_q  <= buf_full_d;
      ready_q     <= !buf_full_d;
      underflow_q <= underflow_d;
      fs_q        <= 1'b0;
      if (xfer) buf_q <= frame_data_i;

      if (load) begin
        state_q <= ST_RUN;
        b_q     <= '0;
        div_q   <= div_i;
        mode_q  <= mode_i;
        fs_q    <= 1'b1;
        sck_q   <= 1'b0;
        ws_q    <= ws_raw(0, NUM_CH, SLOT_W);
        // Philips b=0 repeats the outgoing frame's last bit; shift_q is 0 out of IDLE.
        sd_q    <= (mode_i == I2S_MODE_LJ) ? (buf_full_q && frame_pad[FB-1]) : shift_q[FB-1];
        shift_q <= buf_full_q ? frame_pad : '0;
      end else if (state_q == ST_RUN) begin
        if (!en_i) begin
          state_q <= ST_IDLE;
          b_q     <= '0;
          shift_q <= '0;
          sck_q   <= 1'b0;
          ws_q    <= 1'b0;
          sd_q    <= 1'b0;
        end else if (sck_rise) begin
          sck_q <= 1'b1;
        end else if (sck_fall) begin
          sck_q   <= 1'b0;
          b_q     <= b_q + 1'b1;
          shift_q <= shift_q << 1;
          ws_q    <= ws_raw(int'(b_q) + 1, NUM_CH, SLOT_W);
          sd_q    <= (mode_q == I2S_MODE_LJ) ? shift_q[FB-2] : shift_q[FB-1];
        end
      end
    end
  end

  assign frame_ready_o = ready_q;
  assign sck_o         = sck_q;
  assign ws_o          = ws_q;
  assign sd_o          = sd_q;
  assign frame_start_o = fs_q;
  assign underflow_o   = underflow_q;

endmodule

// File: tb/tb_i2s_tdm_tx.sv
// Directed bench: a stereo instance and a 4-channel TDM instance of i2s_tdm_tx.
`timescale 1ns/1ps
module tb_i2s_tdm_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_s, mode_s, valid_s, clr_s;
  logic [3:0]  div_s;
  logic [15:0] data_s;
  logic        ready_s, sck_s, ws_s, sd_s, fs_s, uf_s;
  logic        en_t, mode_t, valid_t, clr_t;
  logic [3:0]  div_t;
  logic [31:0] data_t;
  logic        ready_t, sck_t, ws_t, sd_t, fs_t, uf_t;

  i2s_tdm_tx #(.AUDIO_DW(8), .SLOT_W(8), .NUM_CH(2), .DIV_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_s), .div_i(div_s), .mode_i(mode_s),
    .frame_data_i(data_s), .frame_valid_i(valid_s), .frame_ready_o(ready_s),
    .sck_o(sck_s), .ws_o(ws_s), .sd_o(sd_s), .frame_start_o(fs_s),
    .underflow_o(uf_s), .underflow_clr_i(clr_s)
  );

  i2s_tdm_tx #(.AUDIO_DW(8), .SLOT_W(16), .NUM_CH(4), .DIV_W(4)) u_tdm (
    .clk(clk), .rst_n(rst_n), .en_i(en_t), .div_i(div_t), .mode_i(mode_t),
    .frame_data_i(data_t), .frame_valid_i(valid_t), .frame_ready_o(ready_t),
    .sck_o(sck_t), .ws_o(ws_t), .sd_o(sd_t), .frame_start_o(fs_t),
    .underflow_o(uf_t), .underflow_clr_i(clr_t)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %h", tag, got);
    end
  endtask

  // Observation mux so the same capture tasks serve both instances.
  logic sel_tdm = 1'b0;
  logic m_sck, m_ws, m_sd, m_fs, m_rdy;
  always_comb begin
    m_sck = sel_tdm ? sck_t   : sck_s;
    m_ws  = sel_tdm ? ws_t    : ws_s;
    m_sd  = sel_tdm ? sd_t    : sd_s;
    m_fs  = sel_tdm ? fs_t    : fs_s;
    m_rdy = sel_tdm ? ready_t : ready_s;
  end

  // Stereo source: presents queued frames, pops one after each accepted transfer.
  logic [15:0] tx_q[$];
  logic        rdy_seen = 1'b0;
  initial begin
    valid_s = 1'b0;
    data_s  = '0;
    forever begin
      @(negedge clk);
      if (valid_s && rdy_seen && tx_q.size() > 0) begin
        $display("[TB] frame %h accepted", tx_q[0]);
        void'(tx_q.pop_front());
      end
      valid_s  = (tx_q.size() > 0);
      data_s   = valid_s ? tx_q[0] : 16'h0000;
      rdy_seen = ready_s;
    end
  end

  task automatic wait_start(input string tag, input int budget, output int waited);
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!m_fs && waited < budget);
    check(tag, m_fs, 1);
  endtask

  // Called on the frame_start negedge; samples each bit at its first negedge.
  task automatic capture(input int nbits, input int period,
                         output logic [63:0] sd_v, output logic [63:0] ws_v,
                         output int rdy_cnt, output int fs_cnt, output logic [3:0] sck4);
    sd_v = '0; ws_v = '0; rdy_cnt = 0; fs_cnt = 0; sck4 = '0;
    for (int i = 0; i < nbits * period; i++) begin
      if (i > 0) @(negedge clk);
      if (i % period == 0) begin
        sd_v = {sd_v[62:0], m_sd};
        ws_v = {ws_v[62:0], m_ws};
      end
      if (m_rdy) rdy_cnt++;
      if (m_fs)  fs_cnt++;
      if (i < 4) sck4 = {sck4[2:0], m_sck};
    end
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] sdv, wsv;
    logic [5:0]  pre;
    logic [3:0]  s4;
    int          rc, fc, w;

    rst_n = 1'b0; en_s = 1'b0; mode_s = 1'b1; clr_s = 1'b0; div_s = 4'd0;
    en_t = 1'b0; mode_t = 1'b1; clr_t = 1'b0; div_t = 4'd3; valid_t = 1'b0; data_t = '0;
    repeat (3) @(negedge clk);
    check("rst_outs", {sck_s, ws_s, sd_s, fs_s, uf_s, ready_s}, 6'b000001);
    rst_n = 1'b1;

    // Left-justified stereo, single preloaded frame
    tx_q.push_back(16'hA53C);
    repeat (3) @(negedge clk);
    check("preload_ready", ready_s, 0);
    en_s = 1'b1;
    wait_start("fs_first", 8, w);
    capture(16, 2, sdv, wsv, rc, fc, s4);
    check("lj_sd", sdv, 16'h3CA5);
    check("lj_ws", wsv, 16'h00FF);
    check("lj_sck", s4, 4'b0101);
    check("lj_fs_pulse", fc, 1);

    // Second frame underflows; clear held across the next load: set wins
    wait_start("fs_uf", 40, w);
    check("fs_period", 31 + w, 32);
    check("uf_set", uf_s, 1);
    capture(16, 2, sdv, wsv, rc, fc, s4);
    check("uf_sd_zero", sdv, 0);
    clr_s = 1'b1;
    wait_start("fs_uf2", 40, w);
    check("uf_set_wins", uf_s, 1);
    @(negedge clk);
    clr_s = 1'b0;
    check("uf_clr", uf_s, 0);

    // Philips mode, two identical frames
    mode_s = 1'b0;
    tx_q.push_back(16'hA53C);
    tx_q.push_back(16'hA53C);
    wait_start("fs_ph1", 40, w);
    check("uf_stays_clr", uf_s, 0);
    capture(16, 2, sdv, wsv, rc, fc, s4);
    check("ph_sd1", sdv, 16'h1E52);
    check("ph_ws", wsv, 16'h00FF);
    wait_start("fs_ph2", 40, w);
    tx_q.push_back(16'h0102);
    tx_q.push_back(16'hF00F);
    tx_q.push_back(16'h5AC7);
    mode_s = 1'b1;
    capture(16, 2, sdv, wsv, rc, fc, s4);
    check("ph_sd2", sdv, 16'h9E52);

    // Backpressure: three queued frames in order
    wait_start("fs_bp0", 40, w);
    capture(16, 2, sdv, wsv, rc, fc, s4);
    check("bp_sd0", sdv, 16'h0201);
    check("bp_rdy0", rc, 1);
    wait_start("fs_bp1", 40, w);
    capture(16, 2, sdv, wsv, rc, fc, s4);
    check("bp_sd1", sdv, 16'h0FF0);
    check("bp_rdy1", rc, 1);

    // Abort at b=5 of the third frame, with a frame waiting in the buffer
    wait_start("fs_bp2", 40, w);
    tx_q.push_back(16'h6699);
    pre = '0;
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) @(negedge clk);
      if (i % 2 == 0) pre = {pre[4:0], sd_s};
    end
    check("bp_sd2_prefix", pre, 6'b110001);
    en_s = 1'b0;
    @(negedge clk);
    check("ab_idle", {sck_s, ws_s, sd_s}, 3'b000);
    @(negedge clk);
    check("ab_buf_kept", ready_s, 0);
    @(negedge clk);
    en_s = 1'b1;
    wait_start("fs_resume", 4, w);
    check("ab_resume_lat", w, 1);
    capture(16, 2, sdv, wsv, rc, fc, s4);
    check("ab_resume_sd", sdv, 16'h9966);

    // Reset mid-frame with en_i held high
    wait_start("fs_pre_rst", 40, w);
    tx_q.push_back(16'h1234);
    repeat (6) @(negedge clk);
    check("pre_rst", {uf_s, ready_s}, 2'b10);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid", {sck_s, ws_s, sd_s, fs_s, uf_s, ready_s}, 6'b000001);
    en_s  = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // TDM: 4 x 16-bit slots, 8-bit samples, div 3
    sel_tdm = 1'b1;
    data_t  = 32'h7E81_00C3;
    valid_t = 1'b1;
    @(negedge clk);
    valid_t = 1'b0;
    en_t    = 1'b1;
    wait_start("fs_tdm", 4, w);
    capture(64, 8, sdv, wsv, rc, fc, s4);
    check("tdm_sd", sdv, 64'hC300_0000_8100_7E00);
    check("tdm_ws", wsv, 64'h8000_0000_0000_0000);
    wait_start("fs_tdm2", 16, w);
    check("tdm_period", 511 + w, 512);
    en_t = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
